motor_pwm_driver: RTL and testbench

Consumes the two 8-bit motor command bytes produced by the SPI slave stage and turns them into per-motor PWM and direction outputs for the H-bridges.
- Commands are captured on the system clock when the MCU releases `load`.
- Duty updates are glitch-free; direction reversal inserts dead-time.
- A watchdog stops both motors if the MCU stops sending frames.

---
 rtl/motor_pkg.sv | 13 +
 rtl/motor_channel.sv | 43 ++++
 rtl/motor_pwm_driver.sv | 77 +++++++
 tb/tb_motor_pwm_driver.sv | 154 +++++++++++++++
 4 files changed

// File: rtl/motor_pkg.sv
// motor_pkg: shared types and helpers for the motor PWM driver
package motor_pkg;
  localparam int PWM_MAX = 127;
  typedef logic signed [7:0] cmd_t;
  typedef logic [6:0] duty_t;
  typedef enum logic {DRIVE, DEADTIME} chan_state_t;
  // |cmd| as a duty; -128 has no positive twin so it clamps to full scale
  function automatic duty_t abs_sat(input cmd_t c);
    cmd_t n;
    n = -c;
    return (c == cmd_t'(8'sh80)) ? duty_t'(PWM_MAX) : (c[7] ? n[6:0] : c[6:0]);
  endfunction
endpackage

// File: rtl/motor_channel.sv
// motor_channel: one H-bridge channel with boundary-aligned duty/direction updates and reversal dead-time
module motor_channel
  import motor_pkg::*;
#(
  parameter int DEADTIME_PERIODS = 2
) (
  input  logic  clk,
  input  logic  reset,
  input  logic  i_bnd,
  input  duty_t i_per,
  input  duty_t i_mag,
  input  logic  i_sgn,
  output logic  o_pwm,
  output logic  o_dir
);
  localparam int DW = DEADTIME_PERIODS > 0 ? $clog2(DEADTIME_PERIODS + 1) : 1;
  chan_state_t r_state;
  duty_t r_duty;
  logic r_dir;
  logic [DW-1:0] r_dead;
  assign o_pwm = (r_state == DRIVE) && (i_per < r_duty);
  assign o_dir = r_dir;
  // state, duty and direction only move on period boundaries so no runt pulse can appear
  always_ff @(posedge clk)
    if (reset) begin
      r_state <= DRIVE;
      r_duty <= '0;
      r_dir <= 1'b0;
      r_dead <= '0;
    end else if (i_bnd) begin
      if (r_state == DRIVE && i_mag != '0 && i_sgn != r_dir) begin
        r_state <= DEADTIME;
        r_duty <= '0;
        r_dead <= DW'(DEADTIME_PERIODS);
      end else if (r_state == DRIVE || r_dead <= DW'(1)) begin
        r_state <= DRIVE;
        r_duty <= i_mag;
        r_dir <= (i_mag != '0) ? i_sgn : r_dir;
        r_dead <= '0;
      end else
        r_dead <= r_dead - 1'b1;
    end
endmodule

// File: rtl/motor_pwm_driver.sv
// motor_pwm_driver: captures MCU motor commands and drives two PWM/direction channels with a frame watchdog
module motor_pwm_driver
  import motor_pkg::*;
#(
  parameter int PRESCALE         = 47,
  parameter int DEADTIME_PERIODS = 2,
  parameter int WDOG_PERIODS     = 100
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       load,
  input  logic [7:0] motor1,
  input  logic [7:0] motor2,
  output logic       pwm1,
  output logic       dir1,
  output logic       pwm2,
  output logic       dir2,
  output logic       timeout
);
  localparam int PW = PRESCALE > 0 ? $clog2(PRESCALE + 1) : 1;
  localparam int WW = $clog2(WDOG_PERIODS + 1);
  logic [2:0] r_sync;
  logic [PW-1:0] r_pre;
  duty_t r_per, r_mag1, r_mag2;
  logic r_sgn1, r_sgn2, r_to;
  logic [WW-1:0] r_wd;
  logic w_cap, w_tick, w_bnd;
  assign w_cap = r_sync[1] & ~r_sync[2];
  assign w_tick = r_pre == PW'(PRESCALE);
  assign w_bnd = w_tick && r_per == duty_t'(PWM_MAX - 1);
  assign timeout = r_to;
  // two-stage synchronizer plus history bit; resets high so a load already high is not seen as a new frame
  always_ff @(posedge clk)
    if (reset) r_sync <= '1;
    else r_sync <= {r_sync[1:0], load};
  // prescaler and shared period counter
  always_ff @(posedge clk)
    if (reset) begin
      r_pre <= '0;
      r_per <= '0;
    end else begin
      r_pre <= w_tick ? '0 : r_pre + 1'b1;
      if (w_tick) r_per <= w_bnd ? '0 : r_per + 1'b1;
    end
  // capture of pending commands and the watchdog; a capture beats a coincident expiry
  always_ff @(posedge clk)
    if (reset) begin
      r_mag1 <= '0;
      r_mag2 <= '0;
      r_sgn1 <= 1'b0;
      r_sgn2 <= 1'b0;
      r_wd <= '0;
      r_to <= 1'b1;
    end else if (w_cap) begin
      r_mag1 <= abs_sat(cmd_t'(motor1));
      r_mag2 <= abs_sat(cmd_t'(motor2));
      r_sgn1 <= motor1[7];
      r_sgn2 <= motor2[7];
      r_wd <= '0;
      r_to <= 1'b0;
    end else if (w_bnd && r_wd != WW'(WDOG_PERIODS)) begin
      r_wd <= r_wd + 1'b1;
      if (r_wd == WW'(WDOG_PERIODS - 1)) begin
        r_to <= 1'b1;
        r_mag1 <= '0;
        r_mag2 <= '0;
      end
    end
  motor_channel #(.DEADTIME_PERIODS(DEADTIME_PERIODS)) u_ch1 (
    .clk(clk), .reset(reset), .i_bnd(w_bnd), .i_per(r_per),
    .i_mag(r_mag1), .i_sgn(r_sgn1), .o_pwm(pwm1), .o_dir(dir1)
  );
  motor_channel #(.DEADTIME_PERIODS(DEADTIME_PERIODS)) u_ch2 (
    .clk(clk), .reset(reset), .i_bnd(w_bnd), .i_per(r_per),
    .i_mag(r_mag2), .i_sgn(r_sgn2), .o_pwm(pwm2), .o_dir(dir2)
  );
endmodule

// File: tb/tb_motor_pwm_driver.sv
// tb_motor_pwm_driver: directed checks of capture latency, duty, dead-time, watchdog and reset
module tb_motor_pwm_driver;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic load = 1'b1;
  logic [7:0] motor1 = 8'h00;
  logic [7:0] motor2 = 8'h00;
  logic pwm1, dir1, pwm2, dir2, timeout;
  int tests = 0;
  int fails = 0;
  int per_m = 0;

  motor_pwm_driver #(.PRESCALE(0), .DEADTIME_PERIODS(2), .WDOG_PERIODS(4)) dut (
    .clk(clk), .reset(reset), .load(load), .motor1(motor1), .motor2(motor2),
    .pwm1(pwm1), .dir1(dir1), .pwm2(pwm2), .dir2(dir2), .timeout(timeout)
  );

  always #5 clk = ~clk;

  // expected position in the 127-tick period (one tick per clock)
  always @(posedge clk) per_m <= (reset || per_m == 126) ? 0 : per_m + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %0d required %0d", tag, obs, exp);
    end
  endtask

  task automatic wait_start(input string tag);
    int n = 0;
    while (per_m != 0 && n < 300) begin
      @(negedge clk);
      n++;
    end
    chk(tag, per_m, 0);
  endtask

  // one full period, sampled per tick; optionally sends a frame early in the period
  task automatic measure(input string tag, input int d1, input int d2, input logic r1,
                         input logic r2, input bit snd, input logic [7:0] m1, input logic [7:0] m2);
    int e1 = 0, e2 = 0, h1 = 0, h2 = 0, ed1 = 0, ed2 = 0;
    for (int i = 0; i < 127; i++) begin
      if (snd && i == 4) begin
        load = 1'b0;
        motor1 = m1;
        motor2 = m2;
      end
      if (snd && i == 6) load = 1'b1;
      h1 += int'(pwm1);
      h2 += int'(pwm2);
      if (pwm1 !== (i < d1)) e1++;
      if (pwm2 !== (i < d2)) e2++;
      if (dir1 !== r1) ed1++;
      if (dir2 !== r2) ed2++;
      @(negedge clk);
    end
    tests += 4;
    assert (e1 === 0) else begin
      fails++;
      $error("FAIL %s pwm1: high=%0d required=%0d bad_samples=%0d", tag, h1, d1, e1);
    end
    assert (e2 === 0) else begin
      fails++;
      $error("FAIL %s pwm2: high=%0d required=%0d bad_samples=%0d", tag, h2, d2, e2);
    end
    assert (ed1 === 0) else begin
      fails++;
      $error("FAIL %s dir1: bad_samples=%0d required=%0d", tag, ed1, r1);
    end
    assert (ed2 === 0) else begin
      fails++;
      $error("FAIL %s dir2: bad_samples=%0d required=%0d", tag, ed2, r2);
    end
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_pwm1", pwm1, 0);
    chk("rst_dir1", dir1, 0);
    chk("rst_pwm2", pwm2, 0);
    chk("rst_dir2", dir2, 0);
    chk("rst_timeout", timeout, 1);
    reset = 1'b0;
    load = 1'b0;
    motor1 = 8'h40;
    motor2 = 8'h00;
    @(negedge clk);
    load = 1'b1;
    @(negedge clk);
    chk("cap_edge1_timeout", timeout, 1);
    @(negedge clk);
    chk("cap_edge2_timeout", timeout, 1);
    @(negedge clk);
    chk("cap_edge3_timeout", timeout, 0);
    wait_start("sync_p1");
    measure("p1_duty64", 64, 0, 0, 0, 1, 8'h40, 8'h00);
    measure("p2_duty64", 64, 0, 0, 0, 1, 8'h7F, 8'h00);
    measure("p3_full", 127, 0, 0, 0, 1, 8'h80, 8'h00);
    measure("p4_dead1", 0, 0, 0, 0, 1, 8'h80, 8'h00);
    measure("p5_dead2", 0, 0, 0, 0, 1, 8'h80, 8'h00);
    measure("p6_neg128", 127, 0, 1, 0, 1, 8'h80, 8'h00);
    measure("p7_m2_rev", 127, 0, 1, 0, 1, 8'h80, 8'hF0);
    measure("p8_m2_dead1", 127, 0, 1, 0, 1, 8'h80, 8'hF0);
    measure("p9_m2_dead2", 127, 0, 1, 0, 1, 8'h80, 8'hF0);
    measure("p10_m2_neg16", 127, 16, 1, 1, 1, 8'h80, 8'h10);
    measure("p11_m2_dead1", 127, 0, 1, 1, 1, 8'h80, 8'h10);
    measure("p12_m2_dead2", 127, 0, 1, 1, 1, 8'h80, 8'h10);
    measure("p13_m2_pos16", 127, 16, 1, 0, 1, 8'h80, 8'hF0);
    measure("p14_dead_ovr1", 127, 0, 1, 0, 1, 8'h80, 8'h10);
    measure("p15_dead_ovr2", 127, 0, 1, 0, 1, 8'h80, 8'h10);
    measure("p16_resume16", 127, 16, 1, 0, 0, 8'h00, 8'h00);
    measure("p17_idle", 127, 16, 1, 0, 0, 8'h00, 8'h00);
    chk("wd_before_expiry", timeout, 0);
    measure("p18_idle", 127, 16, 1, 0, 0, 8'h00, 8'h00);
    chk("wd_expired", timeout, 1);
    measure("p19_still_on", 127, 16, 1, 0, 0, 8'h00, 8'h00);
    chk("wd_held", timeout, 1);
    measure("p20_stopped", 0, 0, 1, 0, 1, 8'h20, 8'h00);
    chk("wd_cleared", timeout, 0);
    measure("p21_dead1", 0, 0, 1, 0, 1, 8'h20, 8'h00);
    measure("p22_dead2", 0, 0, 1, 0, 1, 8'h20, 8'h00);
    measure("p23_duty32", 32, 0, 0, 0, 1, 8'h64, 8'h00);
    measure("p24_duty100", 100, 0, 0, 0, 1, 8'h0A, 8'h00);
    measure("p25_duty10", 10, 0, 0, 0, 1, 8'h80, 8'h7F);
    repeat (60) @(negedge clk);
    chk("mid_dead_pwm1", pwm1, 0);
    chk("mid_dead_dir1", dir1, 0);
    chk("mid_full_pwm2", pwm2, 1);
    reset = 1'b1;
    @(negedge clk);
    chk("rst2_pwm1", pwm1, 0);
    chk("rst2_dir1", dir1, 0);
    chk("rst2_pwm2", pwm2, 0);
    chk("rst2_dir2", dir2, 0);
    chk("rst2_timeout", timeout, 1);
    @(negedge clk);
    reset = 1'b0;
    wait_start("sync_post_rst");
    measure("post_rst_a", 0, 0, 0, 0, 0, 8'h00, 8'h00);
    measure("post_rst_b", 0, 0, 0, 0, 1, 8'h40, 8'h40);
    chk("post_rst_cap", timeout, 0);
    measure("post_rst_run", 64, 64, 0, 0, 0, 8'h00, 8'h00);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end
endmodule
